lsu_req_arb: RTL and testbench

- Sits between the dual-issue issuer / complex (AMO) unit and the LS pipeline.
- Arbitrates LSU requests from two sources: the normal issue path and the complex unit.
- Registers the winning request into a single output stage.
- Tracks outstanding requests in a tag FIFO so each LS pipeline response is routed back to the source that issued it.
- Holds a lock across an AMO read/write pair so no other request can interleave between them.

---
 rtl/lsu_req_arb_if.sv | 58 +++++
 rtl/lsu_req_arb.sv | 180 ++++++++++++++++++
 tb/tb_lsu_req_arb.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_req_arb_if.sv
// Shared request/response types and the request/response bundle for lsu_req_arb.
// The package comes first so both the interface and the arbiter can import it.
package lsu_req_arb_pkg;

  typedef struct packed {
    logic [3:0]  amo_flag;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_info_t;

  typedef struct packed {
    logic        err;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } pl_out_t;

  localparam lsu_req_info_t NULL_LSU_REQ_INFO = '{amo_flag: 4'b0000, we: 1'b0,
                                                  addr: 32'h0000_0000, wdata: 32'h0000_0000};
  localparam logic [3:0] AMO_RD_FLAG = 4'b0100;
  localparam logic [3:0] AMO_WR_FLAG = 4'b1000;

endpackage

interface lsu_req_arb_if;
  import lsu_req_arb_pkg::*;

  logic          is_req_valid_i;
  lsu_req_info_t is_req_info_i;
  logic          is_req_rdy_o;
  logic          cmplx_req_valid_i;
  lsu_req_info_t cmplx_req_info_i;
  logic          cmplx_req_rdy_o;
  logic          lsu_req_valid_o;
  lsu_req_info_t lsu_req_info_o;
  logic          lsu_req_rdy_i;
  logic          lsu_resp_valid_i;
  pl_out_t       lsu_resp_i;
  logic          is_resp_valid_o;
  logic          cmplx_resp_valid_o;
  pl_out_t       resp_o;
  logic          resp_orphan_o;

  modport slave (
    input  is_req_valid_i, is_req_info_i, cmplx_req_valid_i, cmplx_req_info_i,
    input  lsu_req_rdy_i, lsu_resp_valid_i, lsu_resp_i,
    output is_req_rdy_o, cmplx_req_rdy_o, lsu_req_valid_o, lsu_req_info_o,
    output is_resp_valid_o, cmplx_resp_valid_o, resp_o, resp_orphan_o
  );

  modport master (
    output is_req_valid_i, is_req_info_i, cmplx_req_valid_i, cmplx_req_info_i,
    output lsu_req_rdy_i, lsu_resp_valid_i, lsu_resp_i,
    input  is_req_rdy_o, cmplx_req_rdy_o, lsu_req_valid_o, lsu_req_info_o,
    input  is_resp_valid_o, cmplx_resp_valid_o, resp_o, resp_orphan_o
  );

endinterface

// File: rtl/lsu_req_arb.sv
// LSU request arbiter: complex-unit priority, AMO lock, single output stage, tag FIFO routing.
// Optional grant/stall statistics counters are enabled by defining LSU_ARB_STATS_EN.
module lsu_req_arb
  import lsu_req_arb_pkg::*;
#(
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  lsu_req_arb_if.slave  bus
`ifdef LSU_ARB_STATS_EN
  ,
  output logic [31:0]   stat_is_o,
  output logic [31:0]   stat_cmplx_o,
  output logic [31:0]   stat_stall_o
`endif
);

  localparam int unsigned PTR_W = $clog2(OUTST_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTST_DEPTH);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e            lock_state_r, lock_state_s;
  logic                   out_valid_r;
  lsu_req_info_t          out_info_r;
  logic                   out_src_r;
  logic [OUTST_DEPTH-1:0] src_q_r;
  logic [OUTST_DEPTH-1:0] kill_q_r;
  logic [PTR_W-1:0]       wptr_r, rptr_r;
  logic [CNT_W-1:0]       fifo_cnt_r;
  logic                   orphan_r;

  logic [CNT_W-1:0]       occ_s;
  logic                   space_s, cmplx_acc_s, is_acc_s, push_s, pop_s;
  logic                   head_live_s, cmplx_resp_s, is_resp_s;

  // Occupancy, grant and FIFO handshake decode
  always_comb begin
    occ_s        = fifo_cnt_r + {{PTR_W{1'b0}}, out_valid_r};
    space_s      = ~flush_i & (~out_valid_r | bus.lsu_req_rdy_i) & (occ_s < DEPTH_C);
    cmplx_acc_s  = space_s & bus.cmplx_req_valid_i;
    is_acc_s     = space_s & (lock_state_r == IDLE) & ~bus.cmplx_req_valid_i & bus.is_req_valid_i;
    push_s       = out_valid_r & bus.lsu_req_rdy_i;
    pop_s        = bus.lsu_resp_valid_i & (fifo_cnt_r != {CNT_W{1'b0}});
    head_live_s  = pop_s & ~kill_q_r[rptr_r] & ~flush_i;
    cmplx_resp_s = head_live_s & src_q_r[rptr_r];
    is_resp_s    = head_live_s & ~src_q_r[rptr_r];
  end

  assign bus.cmplx_req_rdy_o    = space_s & bus.cmplx_req_valid_i;
  assign bus.is_req_rdy_o       = space_s & (lock_state_r == IDLE) & ~bus.cmplx_req_valid_i;
  assign bus.lsu_req_valid_o    = out_valid_r;
  assign bus.lsu_req_info_o     = out_info_r;
  assign bus.cmplx_resp_valid_o = cmplx_resp_s;
  assign bus.is_resp_valid_o    = is_resp_s;
  assign bus.resp_o             = bus.lsu_resp_i;
  assign bus.resp_orphan_o      = orphan_r;

  // Lock next-state: held from AMO read accept until AMO write accept or an erroring read response
  always_comb begin
    lock_state_s = lock_state_r;
    if (flush_i) begin
      lock_state_s = IDLE;
    end else begin
      case (lock_state_r)
        IDLE: begin
          if (cmplx_acc_s && (bus.cmplx_req_info_i.amo_flag == AMO_RD_FLAG)) begin
            lock_state_s = LOCKED;
          end else begin
            lock_state_s = IDLE;
          end
        end
        LOCKED: begin
          if (cmplx_acc_s && (bus.cmplx_req_info_i.amo_flag == AMO_WR_FLAG)) begin
            lock_state_s = IDLE;
          end else if (cmplx_resp_s && bus.lsu_resp_i.err) begin
            lock_state_s = IDLE;
          end else begin
            lock_state_s = LOCKED;
          end
        end
        default: lock_state_s = IDLE;
      endcase
    end
  end

  // Lock state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_state_r <= IDLE;
    end else begin
      lock_state_r <= lock_state_s;
    end
  end

  // Output stage: load the winner, drop on hand-off or flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
      out_info_r  <= NULL_LSU_REQ_INFO;
      out_src_r   <= 1'b0;
    end else if (cmplx_acc_s) begin
      out_valid_r <= 1'b1;
      out_info_r  <= bus.cmplx_req_info_i;
      out_src_r   <= 1'b1;
    end else if (is_acc_s) begin
      out_valid_r <= 1'b1;
      out_info_r  <= bus.is_req_info_i;
      out_src_r   <= 1'b0;
    end else if (flush_i || bus.lsu_req_rdy_i) begin
      out_valid_r <= 1'b0;
    end
  end

  // Tag FIFO: a flush kills every stored tag and any tag pushed in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q_r    <= {OUTST_DEPTH{1'b0}};
      kill_q_r   <= {OUTST_DEPTH{1'b0}};
      wptr_r     <= {PTR_W{1'b0}};
      rptr_r     <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
      orphan_r   <= 1'b0;
    end else begin
      if (flush_i) begin
        kill_q_r <= {OUTST_DEPTH{1'b1}};
      end
      if (push_s) begin
        src_q_r[wptr_r]  <= out_src_r;
        kill_q_r[wptr_r] <= flush_i;
        wptr_r           <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      if (bus.lsu_resp_valid_i && (fifo_cnt_r == {CNT_W{1'b0}})) begin
        orphan_r <= 1'b1;
      end
    end
  end

`ifdef LSU_ARB_STATS_EN
  logic [31:0] stat_is_r, stat_cmplx_r, stat_stall_r;
  logic        stall_s;

  assign stall_s = (bus.is_req_valid_i & ~is_acc_s) | (bus.cmplx_req_valid_i & ~cmplx_acc_s);

  // Saturating grant and stall counters, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_is_r    <= 32'h0000_0000;
      stat_cmplx_r <= 32'h0000_0000;
      stat_stall_r <= 32'h0000_0000;
    end else begin
      if (is_acc_s && (stat_is_r != 32'hFFFF_FFFF)) begin
        stat_is_r <= stat_is_r + 32'd1;
      end
      if (cmplx_acc_s && (stat_cmplx_r != 32'hFFFF_FFFF)) begin
        stat_cmplx_r <= stat_cmplx_r + 32'd1;
      end
      if (stall_s && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end
    end
  end

  assign stat_is_o    = stat_is_r;
  assign stat_cmplx_o = stat_cmplx_r;
  assign stat_stall_o = stat_stall_r;
`endif

endmodule

// File: tb/tb_lsu_req_arb.sv
// Directed self-checking bench for lsu_req_arb (OUTST_DEPTH = 4).
module tb_lsu_req_arb;
  import lsu_req_arb_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef LSU_ARB_STATS_EN
  logic [31:0] stat_is, stat_cmplx, stat_stall;
`endif

  lsu_req_arb_if bus ();

  lsu_req_arb #(.OUTST_DEPTH(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus)
`ifdef LSU_ARB_STATS_EN
    ,
    .stat_is_o    (stat_is),
    .stat_cmplx_o (stat_cmplx),
    .stat_stall_o (stat_stall)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic lsu_req_info_t mk(input logic [3:0] amo, input logic [31:0] addr);
    lsu_req_info_t r;
    r          = NULL_LSU_REQ_INFO;
    r.amo_flag = amo;
    r.addr     = addr;
    r.wdata    = addr ^ 32'h5A5A_0000;
    return r;
  endfunction

  function automatic pl_out_t mkresp(input logic err, input logic [31:0] d);
    pl_out_t r;
    r.err   = err;
    r.wdata = ~d;
    r.rdata = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resp_on(input logic err, input logic [31:0] d);
    bus.lsu_resp_valid_i = 1'b1;
    bus.lsu_resp_i       = mkresp(err, d);
  endtask

  task automatic chk_route(input string tag, input logic exp_is, input logic exp_cm);
    chk({tag, "_is"}, bus.is_resp_valid_o, exp_is);
    chk({tag, "_cm"}, bus.cmplx_resp_valid_o, exp_cm);
  endtask

  initial begin
    rst_i                 = 1'b1;
    flush_i               = 1'b0;
    bus.is_req_valid_i    = 1'b0;
    bus.is_req_info_i     = NULL_LSU_REQ_INFO;
    bus.cmplx_req_valid_i = 1'b0;
    bus.cmplx_req_info_i  = NULL_LSU_REQ_INFO;
    bus.lsu_req_rdy_i     = 1'b0;
    bus.lsu_resp_valid_i  = 1'b0;
    bus.lsu_resp_i        = mkresp(1'b0, 32'h0000_0000);
    #2;
    chk("rst_valid", bus.lsu_req_valid_o, 1'b0);
    chk("rst_info", bus.lsu_req_info_o, NULL_LSU_REQ_INFO);
    chk("rst_orphan", bus.resp_orphan_o, 1'b0);
    chk("rst_is_rdy", bus.is_req_rdy_o, 1'b1);
    chk("rst_cnt", dut.fifo_cnt_r, 3'd0);
    #1 rst_i = 1'b0;

    // Single issue load, response two cycles after the request is presented
    bus.lsu_req_rdy_i  = 1'b1;
    bus.is_req_valid_i = 1'b1;
    bus.is_req_info_i  = mk(4'b0000, 32'h0000_0100);
    #1;
    chk("t1_is_rdy", bus.is_req_rdy_o, 1'b1);
    chk("t1_cm_rdy", bus.cmplx_req_rdy_o, 1'b0);
    tick();
    chk("t1_out_valid", bus.lsu_req_valid_o, 1'b1);
    chk("t1_out_info", bus.lsu_req_info_o, mk(4'b0000, 32'h0000_0100));
    bus.is_req_valid_i = 1'b0;
    tick();
    chk("t1_out_drop", bus.lsu_req_valid_o, 1'b0);
    chk("t1_cnt1", dut.fifo_cnt_r, 3'd1);
    resp_on(1'b0, 32'h0000_00D1);
    #1;
    chk_route("t1_resp", 1'b1, 1'b0);
    chk("t1_resp_pass", bus.resp_o, mkresp(1'b0, 32'h0000_00D1));
    tick();
    bus.lsu_resp_valid_i = 1'b0;
    chk("t1_cnt0", dut.fifo_cnt_r, 3'd0);

    // AMO read beats a waiting issue request, lock holds until AMO write
    bus.cmplx_req_valid_i = 1'b1;
    bus.cmplx_req_info_i  = mk(4'b0100, 32'h0000_0200);
    bus.is_req_valid_i    = 1'b1;
    bus.is_req_info_i     = mk(4'b0000, 32'h0000_0210);
    #1;
    chk("t2_cm_rdy", bus.cmplx_req_rdy_o, 1'b1);
    chk("t2_is_rdy_prio", bus.is_req_rdy_o, 1'b0);
    tick();
    chk("t2_out_amo_rd", bus.lsu_req_info_o, mk(4'b0100, 32'h0000_0200));
    bus.cmplx_req_valid_i = 1'b0;
    #1;
    chk("t2_is_rdy_lock", bus.is_req_rdy_o, 1'b0);
    tick();
    resp_on(1'b0, 32'h0000_00D2);
    #1;
    chk_route("t2_rd_resp", 1'b0, 1'b1);
    chk("t2_is_rdy_lock2", bus.is_req_rdy_o, 1'b0);
    tick();
    bus.lsu_resp_valid_i = 1'b0;
    #1;
    chk("t2_is_rdy_lock3", bus.is_req_rdy_o, 1'b0);
    bus.cmplx_req_valid_i = 1'b1;
    bus.cmplx_req_info_i  = mk(4'b1000, 32'h0000_0200);
    #1;
    chk("t2_cm_rdy_wr", bus.cmplx_req_rdy_o, 1'b1);
    tick();
    chk("t2_out_amo_wr", bus.lsu_req_info_o, mk(4'b1000, 32'h0000_0200));
    bus.cmplx_req_valid_i = 1'b0;
    #1;
    chk("t2_is_rdy_free", bus.is_req_rdy_o, 1'b1);
    tick();
    chk("t2_out_is", bus.lsu_req_info_o, mk(4'b0000, 32'h0000_0210));
    bus.is_req_valid_i = 1'b0;
    tick();
    resp_on(1'b0, 32'h0000_00D3);
    #1;
    chk_route("t2_wr_resp", 1'b0, 1'b1);
    tick();
    #1;
    chk_route("t2_is_resp", 1'b1, 1'b0);
    tick();
    bus.lsu_resp_valid_i = 1'b0;
    chk("t2_cnt0", dut.fifo_cnt_r, 3'd0);

    // AMO read response with err releases the lock
    bus.cmplx_req_valid_i = 1'b1;
    bus.cmplx_req_info_i  = mk(4'b0100, 32'h0000_0300);
    bus.is_req_valid_i    = 1'b1;
    bus.is_req_info_i     = mk(4'b0000, 32'h0000_0310);
    tick();
    bus.cmplx_req_valid_i = 1'b0;
    tick();
    resp_on(1'b1, 32'h0000_00E3);
    #1;
    chk_route("t3_err_resp", 1'b0, 1'b1);
    chk("t3_is_rdy_lock", bus.is_req_rdy_o, 1'b0);
    tick();
    bus.lsu_resp_valid_i = 1'b0;
    #1;
    chk("t3_is_rdy_free", bus.is_req_rdy_o, 1'b1);
    tick();
    chk("t3_out_is", bus.lsu_req_info_o, mk(4'b0000, 32'h0000_0310));
    bus.is_req_valid_i = 1'b0;
    tick();
    resp_on(1'b0, 32'h0000_00D4);
    #1;
    chk_route("t3_is_resp", 1'b1, 1'b0);
    tick();
    bus.lsu_resp_valid_i = 1'b0;

    // Fill to OUTST_DEPTH, drain in order and refill through the wrapped pointer
    bus.is_req_valid_i = 1'b1;
    bus.is_req_info_i  = mk(4'b0000, 32'h0000_0400);
    tick();
    bus.is_req_valid_i    = 1'b0;
    bus.cmplx_req_valid_i = 1'b1;
    bus.cmplx_req_info_i  = mk(4'b0000, 32'h0000_0410);
    #1;
    chk("t4_cm_rdy", bus.cmplx_req_rdy_o, 1'b1);
    tick();
    bus.cmplx_req_valid_i = 1'b0;
    bus.is_req_valid_i    = 1'b1;
    bus.is_req_info_i     = mk(4'b0000, 32'h0000_0420);
    tick();
    bus.is_req_info_i = mk(4'b0000, 32'h0000_0430);
    #1;
    chk("t4_is_rdy_occ3", bus.is_req_rdy_o, 1'b1);
    tick();
    chk("t4_cnt3", dut.fifo_cnt_r, 3'd3);
    bus.is_req_valid_i    = 1'b0;
    bus.cmplx_req_valid_i = 1'b1;
    bus.cmplx_req_info_i  = mk(4'b0000, 32'h0000_0440);
    #1;
    chk("t4_cm_rdy_full", bus.cmplx_req_rdy_o, 1'b0);
    tick();
    chk("t4_cnt4", dut.fifo_cnt_r, 3'd4);
    chk("t4_out_drop", bus.lsu_req_valid_o, 1'b0);
    resp_on(1'b0, 32'h0000_00D5);
    #1;
    chk_route("t4_r0", 1'b1, 1'b0);
    chk("t4_no_bypass", bus.cmplx_req_rdy_o, 1'b0);
    tick();
    #1;
    chk_route("t4_r1", 1'b0, 1'b1);
    chk("t4_cm_rdy_refill", bus.cmplx_req_rdy_o, 1'b1);
    tick();
    chk("t4_out_refill", bus.lsu_req_info_o, mk(4'b0000, 32'h0000_0440));
    bus.cmplx_req_valid_i = 1'b0;
    #1;
    chk_route("t4_r2", 1'b1, 1'b0);
    tick();
    chk("t4_cnt_pushpop", dut.fifo_cnt_r, 3'd2);
    #1;
    chk_route("t4_r3", 1'b1, 1'b0);
    tick();
    #1;
    chk_route("t4_r4_wrap", 1'b0, 1'b1);
    tick();
    bus.lsu_resp_valid_i = 1'b0;
    chk("t4_cnt0", dut.fifo_cnt_r, 3'd0);

    // Flush with two in flight and one held in the output stage
    bus.is_req_valid_i = 1'b1;
    bus.is_req_info_i  = mk(4'b0000, 32'h0000_0500);
    tick();
    bus.is_req_info_i = mk(4'b0000, 32'h0000_0510);
    tick();
    bus.is_req_info_i = mk(4'b0000, 32'h0000_0520);
    tick();
    bus.is_req_valid_i = 1'b0;
    bus.lsu_req_rdy_i  = 1'b0;
    tick();
    chk("t5_hold_valid", bus.lsu_req_valid_o, 1'b1);
    chk("t5_hold_info", bus.lsu_req_info_o, mk(4'b0000, 32'h0000_0520));
    flush_i = 1'b1;
    #1;
    chk("t5_flush_is_rdy", bus.is_req_rdy_o, 1'b0);
    tick();
    flush_i = 1'b0;
    chk("t5_out_clear", bus.lsu_req_valid_o, 1'b0);
    chk("t5_cnt2", dut.fifo_cnt_r, 3'd2);
    resp_on(1'b0, 32'h0000_00D6);
    #1;
    chk_route("t5_kill0", 1'b0, 1'b0);
    tick();
    #1;
    chk_route("t5_kill1", 1'b0, 1'b0);
    tick();
    chk("t5_cnt0", dut.fifo_cnt_r, 3'd0);
    chk("t5_orphan_clr", bus.resp_orphan_o, 1'b0);
    #1;
    chk_route("t5_orphan_resp", 1'b0, 1'b0);
    tick();
    bus.lsu_resp_valid_i = 1'b0;
    chk("t5_orphan_set", bus.resp_orphan_o, 1'b1);
    tick();
    chk("t5_orphan_sticky", bus.resp_orphan_o, 1'b1);

    // Asynchronous reset while locked with three outstanding
    bus.lsu_req_rdy_i     = 1'b1;
    bus.cmplx_req_valid_i = 1'b1;
    bus.cmplx_req_info_i  = mk(4'b0100, 32'h0000_0600);
    tick();
    bus.cmplx_req_info_i = mk(4'b0000, 32'h0000_0610);
    tick();
    bus.cmplx_req_info_i = mk(4'b0000, 32'h0000_0620);
    tick();
    bus.cmplx_req_valid_i = 1'b0;
    bus.is_req_valid_i    = 1'b1;
    bus.is_req_info_i     = mk(4'b0000, 32'h0000_0630);
    #1;
    chk("t6_is_rdy_lock", bus.is_req_rdy_o, 1'b0);
    chk("t6_cnt2", dut.fifo_cnt_r, 3'd2);
    #1 rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", bus.lsu_req_valid_o, 1'b0);
    chk("t6_rst_info", bus.lsu_req_info_o, NULL_LSU_REQ_INFO);
    chk("t6_rst_orphan", bus.resp_orphan_o, 1'b0);
    chk("t6_rst_cnt", dut.fifo_cnt_r, 3'd0);
    chk("t6_rst_is_rdy", bus.is_req_rdy_o, 1'b1);
    #1 rst_i = 1'b0;
    tick();
    chk("t6_out_is", bus.lsu_req_info_o, mk(4'b0000, 32'h0000_0630));
    bus.is_req_valid_i = 1'b0;
    tick();
    resp_on(1'b0, 32'h0000_00D7);
    #1;
    chk_route("t6_resp", 1'b1, 1'b0);
    tick();
    bus.lsu_resp_valid_i = 1'b0;
    chk("t6_cnt0", dut.fifo_cnt_r, 3'd0);
    chk("t6_orphan", bus.resp_orphan_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
